// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int IFU_XLEN = 32;

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} ifu_state_t;

    localparam logic [IFU_XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [IFU_XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Fetch queue: synchronous FIFO of {pc, instr} entries with a single-cycle flush.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fq_entry_t               din,
    output fq_entry_t               dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   cnt;
    logic          do_push, do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage carries no reset; occupancy is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == (PW+1)'(DEPTH));
    assign count = cnt;

    // Upstream credit accounting must make this impossible.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC generation, imem req/gnt/rvalid handshake, fetch queue to F/D.
// Optional IFU_MISALIGN_CHECK_EN: a misaligned redirect raises a sticky fault presenting a NOP.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_IFU,
    input  logic            branch_E,
    input  logic [XLEN-1:0] branch_target_E,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            valid_F,
    output logic [XLEN-1:0] pc_F,
    output logic [XLEN-1:0] instr_F,
    output logic            misalign_F
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    ifu_state_t      state;
    logic [XLEN-1:0] fetch_pc, resp_pc, tgt;
    logic [CW-1:0]   outstanding, drop_cnt, remaining, q_count;
    logic            grant, drop, push, pop, credit_ok, q_full, q_empty, fault;
    fq_entry_t       q_din, q_head;

    // Buffered plus in-flight words never exceed the queue depth.
    assign credit_ok = ~q_full & ((outstanding + q_count) < CW'(FQ_DEPTH));
    assign imem_req  = (state == FETCH) & credit_ok & ~branch_E & ~fault;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    assign remaining = outstanding - CW'(imem_rvalid);
    assign drop      = imem_rvalid & (drop_cnt != '0);
    assign push      = imem_rvalid & (drop_cnt == '0) & ~branch_E;
    assign pop       = ~q_empty & enable_IFU & ~branch_E & ~fault;

    assign q_din.pc    = resp_pc;
    assign q_din.instr = imem_rdata;

    ifu_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_E),
        .din   (q_din),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (branch_E) begin
                fetch_pc <= tgt;
                resp_pc  <= tgt;
                drop_cnt <= remaining;
            end else begin
                if (grant) fetch_pc <= fetch_pc + PC_STEP;
                if (push)  resp_pc  <= resp_pc + PC_STEP;
                if (drop)  drop_cnt <= drop_cnt - CW'(1);
            end
            case (state)
                BOOT:  state <= FETCH;
                FETCH: if (branch_E && remaining != '0) state <= DRAIN;
                DRAIN: begin
                    if (branch_E)
                        state <= (remaining != '0) ? DRAIN : FETCH;
                    else if (drop && drop_cnt == CW'(1))
                        state <= FETCH;
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    logic [XLEN-1:0] fault_pc;

    assign tgt = branch_target_E;

    // Sticky until reset or the next redirect, which re-evaluates alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault    <= 1'b0;
            fault_pc <= RESET_PC;
        end else if (branch_E) begin
            fault    <= |branch_target_E[1:0];
            fault_pc <= branch_target_E;
        end
    end

    assign valid_F    = fault | ~q_empty;
    assign pc_F       = fault ? fault_pc : q_head.pc;
    assign instr_F    = fault ? NOP_INSTR : q_head.instr;
    assign misalign_F = fault;
`else
    assign fault      = 1'b0;
    assign tgt        = branch_target_E & ~XLEN'(3);
    assign valid_F    = ~q_empty;
    assign pc_F       = q_head.pc;
    assign instr_F    = q_head.instr;
    assign misalign_F = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch against a request-tagging memory and PC-stream model.
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_IFU, branch_E, imem_req, imem_gnt, imem_rvalid, valid_F, misalign_F;
    logic [31:0] branch_target_E, imem_addr, imem_rdata, pc_F, instr_F;

    ifu_fetch #(.XLEN(32), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_IFU      (enable_IFU),
        .branch_E        (branch_E),
        .branch_target_E (branch_target_E),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .valid_F         (valid_F),
        .pc_F            (pc_F),
        .instr_F         (instr_F),
        .misalign_F      (misalign_F)
    );

    always #5 clk = ~clk;

    // Each request is tagged with the redirect epoch it was issued in.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] dut_issue[$], dut_acc[$];
    logic [31:0] m_fetch_pc, m_fault_pc, force_tgt;
    int          m_epoch, cyc, last_due;
    bit          m_boot, m_fault, br_on_rv, force_br;
    int          gnt_pct, en_pct, rv_pct, br_pm, lat_min, lat_max;
    int          n_checks, n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i].epoch != m_epoch) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_at(input string name, input logic [31:0] q[$], input int idx,
                          input logic [31:0] exp);
        if (idx < q.size()) chk(name, q[idx], exp);
        else begin
            n_checks++;
            n_err++;
            $display("FAIL %s: entry %0d missing, expected %h", name, idx, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable_IFU = 0; branch_E = 0; imem_gnt = 0; imem_rvalid = 0;
        branch_target_E = '0; imem_rdata = '0;
        #1;
        chk("rst_valid_F", valid_F, 1'b0);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_misalign_F", misalign_F, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        mq.delete(); exp_q.delete(); dut_issue.delete(); dut_acc.delete();
        m_fetch_pc = RST_PC; m_epoch = 0; m_boot = 1; m_fault = 0; m_fault_pc = RST_PC;
        cyc = 0; last_due = -1;
    endtask

    // One clock: drive inputs, compare every output with the model, advance the model.
    task automatic step();
        bit          rv, br, exp_req, exp_valid, pop;
        logic [31:0] tgt, exp_pc;
        mreq_t       h;
        int          lat;
        @(negedge clk);
        rv = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rv_pct);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mq[0].addr) : $urandom();
        enable_IFU  = ($urandom_range(99) < en_pct);
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        br = force_br || (br_on_rv && rv) || ($urandom_range(999) < br_pm);
`ifdef IFU_MISALIGN_CHECK_EN
        tgt = (force_br || br_on_rv) ? force_tgt : 32'($urandom_range(0, 1023)) << 2;
`else
        tgt = (force_br || br_on_rv) ? force_tgt : 32'($urandom_range(0, 4095));
`endif
        if (br_on_rv && rv) br_on_rv = 0;
        force_br = 0;
        branch_E = br;
        branch_target_E = tgt;
        #1;
        exp_req   = !m_boot && stale_cnt() == 0 && (mq.size() + exp_q.size() < DEPTH)
                    && !br && !m_fault;
        exp_valid = m_fault || exp_q.size() > 0;
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
        chk("valid_F", valid_F, exp_valid);
        chk("misalign_F", misalign_F, m_fault);
        if (exp_valid) begin
            exp_pc = m_fault ? m_fault_pc : exp_q[0];
            chk("pc_F", pc_F, exp_pc);
            chk("instr_F", instr_F, m_fault ? NOP_INSTR : mem_word(exp_pc));
        end
        if (imem_req && imem_gnt) dut_issue.push_back(imem_addr);
        if (valid_F && enable_IFU && !br) dut_acc.push_back(pc_F);

        pop = !br && !m_fault && exp_q.size() > 0 && enable_IFU;
        if (pop) void'(exp_q.pop_front());
        if (rv) begin
            h = mq.pop_front();
            if (h.epoch == m_epoch && !br) exp_q.push_back(h.addr);
        end
        if (exp_req && imem_gnt) begin
            lat = $urandom_range(lat_max, lat_min);
            h.addr = m_fetch_pc;
            h.epoch = m_epoch;
            h.due = cyc + lat;
            if (h.due <= last_due) h.due = last_due + 1;
            last_due = h.due;
            mq.push_back(h);
            m_fetch_pc += 32'd4;
        end
        if (br) begin
            exp_q.delete();
            m_epoch++;
`ifdef IFU_MISALIGN_CHECK_EN
            m_fault = (tgt[1:0] != 2'b00);
            m_fault_pc = tgt;
            m_fetch_pc = tgt;
`else
            m_fetch_pc = tgt & ~32'h3;
`endif
        end
        m_boot = 0;
        cyc++;
    endtask

    task automatic wait_valid_after_branch(input string name, input logic [31:0] exp_pc);
        int b = 0;
        do begin step(); b++; end while (!valid_F && b < 40);
        chk({name, "_valid"}, valid_F, 1'b1);
        chk({name, "_pc"}, pc_F, exp_pc);
    endtask

    initial begin
        int b;
        n_checks = 0; n_err = 0;
        force_br = 0; br_on_rv = 0; force_tgt = '0;
        gnt_pct = 100; en_pct = 100; rv_pct = 100; br_pm = 0; lat_min = 1; lat_max = 1;
        do_reset();

        // Single-cycle memory: first word visible on cycle 3.
        b = 0;
        while (!valid_F && b < 20) begin step(); b++; end
        chk("first_valid_cycle", cyc - 1, 32'd3);
        chk("first_pc", pc_F, 32'h0);
        repeat (12) step();
        chk_at("issue0", dut_issue, 0, 32'h0);
        chk_at("issue1", dut_issue, 1, 32'h4);
        chk_at("issue2", dut_issue, 2, 32'h8);
        chk_at("acc0", dut_acc, 0, 32'h0);
        chk_at("acc1", dut_acc, 1, 32'h4);
        chk_at("acc2", dut_acc, 2, 32'h8);

        // Stall with the queue full, then resume.
        en_pct = 0;
        repeat (10) step();
        en_pct = 100;
        repeat (10) step();

        // Redirect with two requests in flight.
        lat_min = 3; lat_max = 4;
        b = 0;
        while (mq.size() < 2 && b < 30) begin step(); b++; end
        chk("two_in_flight", mq.size(), 32'd2);
        force_br = 1; force_tgt = 32'h100;
        wait_valid_after_branch("redirect_100", 32'h100);

        // Redirect coinciding with a response while stalled.
        lat_min = 1; lat_max = 2;
        force_br = 1; force_tgt = 32'h180;
        step();
        en_pct = 0; br_on_rv = 1; force_tgt = 32'h240;
        b = 0;
        while (br_on_rv && b < 40) begin step(); b++; end
        chk("branch_on_rvalid_taken", br_on_rv, 1'b0);
        en_pct = 100;
        wait_valid_after_branch("redirect_240", 32'h240);

        // Grant withheld for four cycles.
        gnt_pct = 0;
        repeat (4) step();
        gnt_pct = 100;
        repeat (10) step();

        // PC wraps modulo 2^32.
        dut_acc.delete();
        force_br = 1; force_tgt = 32'hFFFF_FFF8;
        step();
        b = 0;
        while (dut_acc.size() < 4 && b < 60) begin step(); b++; end
        chk_at("wrap0", dut_acc, 0, 32'hFFFF_FFF8);
        chk_at("wrap1", dut_acc, 1, 32'hFFFF_FFFC);
        chk_at("wrap2", dut_acc, 2, 32'h0);
        chk_at("wrap3", dut_acc, 3, 32'h4);

`ifdef IFU_MISALIGN_CHECK_EN
        force_br = 1; force_tgt = 32'h102;
        step();
        en_pct = 50;
        repeat (6) step();
        chk("fault_misalign", misalign_F, 1'b1);
        chk("fault_valid", valid_F, 1'b1);
        chk("fault_pc", pc_F, 32'h102);
        chk("fault_instr", instr_F, 32'h0000_0013);
        chk("fault_no_req", imem_req, 1'b0);
        en_pct = 100;
        force_br = 1; force_tgt = 32'h200;
        wait_valid_after_branch("fault_clear", 32'h200);
        chk("fault_cleared", misalign_F, 1'b0);
`else
        force_br = 1; force_tgt = 32'h102;
        wait_valid_after_branch("align_force", 32'h100);
`endif

        // Random traffic, a mid-run reset, then more random traffic.
        gnt_pct = 70; en_pct = 70; rv_pct = 80; br_pm = 40; lat_min = 1; lat_max = 4;
        repeat (3000) step();
        do_reset();
        repeat (600) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage (F) of the 5-stage F/D/R/E/W pipeline.
- Generates the PC, talks to instruction memory over a req/gnt + rvalid interface, and buffers returned words in a small fetch queue.
- Presents {valid, pc, instr} to the F/D latch.
- Obeys enable_IFU (stall) from pipeline_control and redirects on a taken branch from Execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FQ_DEPTH, 2, fetch-queue entries; also the credit limit on outstanding + buffered words (power of 2, ≥2).
- XLEN, 32, PC/instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- enable_IFU  in  1  1 = F/D may accept this cycle; 0 = stall, hold output.
- branch_E  in  1  taken branch/jump in Execute, redirect this cycle.
- branch_target_E  in  XLEN  redirect PC.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address.
- imem_gnt  in  1  request accepted when imem_req & imem_gnt.
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after grant.
- imem_rdata  in  XLEN  instruction word.
- valid_F  out  1  instr_F/pc_F hold a live instruction.
- pc_F  out  XLEN  PC of presented instruction.
- instr_F  out  XLEN  presented instruction.
- misalign_F  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async, rst=1), all outputs registered or derived from reset state:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty, state=BOOT.
  - valid_F=0, imem_req=0, misalign_F=0.
- State machine:
  - BOOT→FETCH after 1 cycle, unconditionally.
  - FETCH→DRAIN on branch_E when in-flight requests remaining after this cycle's response > 0.
  - FETCH stays in FETCH on branch_E when none remain.
  - DRAIN→FETCH when drop_cnt reaches 0.
  - DRAIN + branch_E: reload target; remain in DRAIN only while requests are still in flight.
- Issue: in FETCH, imem_req=1 iff outstanding + q_count < FQ_DEPTH and branch_E=0. imem_addr=fetch_pc. On grant, fetch_pc += 4 and outstanding++.
- Response: on imem_rvalid, outstanding--.
  - If drop_cnt>0: decrement drop_cnt and discard the word.
  - Otherwise: push {resp_pc, imem_rdata} into the queue and resp_pc += 4.
  - Credit limit guarantees the queue never overflows; an assertion must flag any push when full.
- Output: valid_F = queue non-empty. pc_F/instr_F = head entry. Pop iff valid_F & enable_IFU.
  - With enable_IFU=0, head and outputs are held stable.
- Redirect (branch_E=1), same cycle:
  - Queue flushed; valid_F=0 from the next cycle.
  - fetch_pc ← resp_pc ← branch_target_E.
  - drop_cnt ← outstanding − (imem_rvalid ? 1 : 0).
  - No request is issued in the redirect cycle.
  - branch_E overrides enable_IFU=0.
- Earliest valid target instruction: cycle redirect+1 (issue) + memory latency.
- Simultaneous push and pop: allowed; count is unchanged.
- Arithmetic: PC adds wrap modulo 2^XLEN. Pointers are log2(FQ_DEPTH) bits; count is log2(FQ_DEPTH)+1 bits.
- rst mid-transaction: all state cleared. Responses arriving after reset to requests issued before it are a memory-side violation and are not supported.

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- Defined:
  - branch_target_E[1:0]≠0 at redirect sets a sticky fault: no further requests are issued.
  - misalign_F=1 with valid_F=1, pc_F=target, instr_F=32'h0000_0013 (NOP).
  - The fault clears only on reset or on a later aligned redirect.
- Undefined: target bits [1:0] are forced to 0 and misalign_F is tied 0.

Decomposition:
- Package ifu_pkg:
  - ifu_state_t enum {BOOT, FETCH, DRAIN}.
  - NOP_INSTR=32'h0000_0013, PC_STEP=4.
  - fq_entry_t struct {pc, instr}.
- One sub-module: ifu_fetch_queue, a synchronous FIFO with push, pop, flush, full, empty and count.

Test Plan:
- Reset, 1-cycle-latency memory, enable_IFU=1 → imem_addr 0,4,8,…; first valid_F on cycle 3 with pc_F=0; one instruction accepted per cycle thereafter.
- Hold enable_IFU=0 for 5 cycles with a full queue → imem_req=0; pc_F/instr_F unchanged; resumes in order with no loss or duplication.
- branch_E with target 0x100 while 2 requests are outstanding → both stale responses dropped; next valid_F has pc_F=0x100.
- branch_E on the same cycle as imem_rvalid and enable_IFU=0 → response dropped; drop_cnt=outstanding−1; redirect still taken.
- imem_gnt low for 4 cycles → imem_addr held stable; no duplicate PCs reach the F/D latch.
- IFU_MISALIGN_CHECK_EN build, target 0x102 → misalign_F=1, instr_F=NOP, no requests; later redirect to 0x200 → fault cleared and fetch resumes.
